// File: rtl/reg_bank_if.sv
// Command channel of the register bank: valid/ready handshake plus the
// operation fields and the data-bus load value that travel with it.
interface reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4
);
  localparam int AW = $clog2(NREG);

  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op;
  logic [AW-1:0]    dst;
  logic [AW-1:0]    src;
  logic [WIDTH-1:0] RIN;

  modport master (output op_valid, op, dst, src, RIN, input op_ready);
  modport slave  (input op_valid, op, dst, src, RIN, output op_ready);
endinterface

// File: rtl/reg_bank.sv
// Bank of NREG general-purpose registers for the model computer datapath.
// Single-cycle LOAD/CLR/INC/DEC/MOV/SHR in place, a two-cycle atomic SWAP
// through a holding register, a tri-state bus driver and zero/carry flags.
module reg_bank #(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 4,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  RESET_N,
  reg_bank_if.slave             cmd,
  input  logic                  outflag,
  input  logic [AW-1:0]         out_sel,
  output logic [WIDTH-1:0]      checkout,
  output logic [NREG*WIDTH-1:0] ROUT,
  output logic                  zero,
  output logic                  carry
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_CLR  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_MOV  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWAP2 = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] regs_r [NREG];
  logic [WIDTH-1:0] regs_s [NREG];
  logic [WIDTH-1:0] tmp_r, tmp_s;
  logic [AW-1:0]    swap_src_r, swap_src_s;
  logic             zero_s, carry_s;
  logic [WIDTH-1:0] cur_dst_s, cur_src_s, result_s;
  logic             write_s;

  // Decode the accepted command into next register, holding-register, flag and FSM values.
  always_comb begin
    state_s    = state_r;
    regs_s     = regs_r;
    tmp_s      = tmp_r;
    swap_src_s = swap_src_r;
    zero_s     = zero;
    carry_s    = carry;
    cur_dst_s  = regs_r[cmd.dst];
    cur_src_s  = regs_r[cmd.src];
    result_s   = cur_dst_s;
    write_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd.op_valid) begin
          write_s = 1'b1;
          carry_s = 1'b0;
          case (cmd.op)
            OP_NOP: begin
              write_s = 1'b0;
              carry_s = carry;
            end
            OP_LOAD: result_s = cmd.RIN;
            OP_CLR:  result_s = ZERO_W;
            OP_INC: begin
              result_s = cur_dst_s + ONE_W;
              carry_s  = &cur_dst_s;
            end
            OP_DEC: begin
              result_s = cur_dst_s - ONE_W;
              carry_s  = ~|cur_dst_s;
            end
            OP_MOV:  result_s = cur_src_s;
            OP_SWAP: begin
              // First half: dst takes src now, old dst parks in TMP; flags wait for the second edge.
              write_s    = 1'b0;
              carry_s    = carry;
              tmp_s      = cur_dst_s;
              swap_src_s = cmd.src;
              regs_s[cmd.dst] = cur_src_s;
              state_s    = ST_SWAP2;
            end
            OP_SHR: begin
              result_s = cur_dst_s >> 1;
              carry_s  = cur_dst_s[0];
            end
            default: begin
              write_s = 1'b0;
              carry_s = carry;
            end
          endcase
          if (write_s) begin
            regs_s[cmd.dst] = result_s;
            zero_s          = (result_s == ZERO_W);
          end else begin
            zero_s = zero;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SWAP2: begin
        // Second half: the source index latched at acceptance receives the parked value.
        regs_s[swap_src_r] = tmp_r;
        zero_s             = (tmp_r == ZERO_W);
        carry_s            = 1'b0;
        state_s            = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, register file, holding register and flags; reset aborts any swap in progress.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r    <= ST_IDLE;
      tmp_r      <= ZERO_W;
      swap_src_r <= {AW{1'b0}};
      zero       <= 1'b0;
      carry      <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= ZERO_W;
      end
    end else begin
      state_r    <= state_s;
      tmp_r      <= tmp_s;
      swap_src_r <= swap_src_s;
      zero       <= zero_s;
      carry      <= carry_s;
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= regs_s[i];
      end
    end
  end

  assign cmd.op_ready = (state_r == ST_IDLE);

  // Flatten the register file onto ROUT, R[i] in slice i.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_rout
    assign ROUT[gi*WIDTH +: WIDTH] = regs_r[gi];
  end

  // Bus driver: released to high impedance whenever outflag is low.
  assign checkout = outflag ? regs_r[out_sel] : {WIDTH{1'bz}};

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank (WIDTH=8, NREG=4): hand-derived vector
// table, swap/reset corner sequences, then random traffic against a model.
module tb_reg_bank;

  logic       clk;
  logic       RESET_N;
  logic       outflag;
  logic [1:0] out_sel;
  wire  [7:0] checkout_w;
  logic [31:0] rout;
  logic       zero, carry;

  reg_bank_if #(.WIDTH(8), .NREG(4)) bif ();

  reg_bank #(.WIDTH(8), .NREG(4)) dut (
    .clk      (clk),
    .RESET_N  (RESET_N),
    .cmd      (bif),
    .outflag  (outflag),
    .out_sel  (out_sel),
    .checkout (checkout_w),
    .ROUT     (rout),
    .zero     (zero),
    .carry    (carry)
  );

  // Weak pull-ups make a released bus read as all ones.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (checkout_w[gi]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: architectural registers plus a pending swap record.
  int m_reg [4];
  int m_zero, m_carry;
  int m_busy, m_sw_b, m_sw_va;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_zero = 0; m_carry = 0; m_busy = 0; m_sw_b = 0; m_sw_va = 0;
  endfunction

  function automatic void model_edge();
    int d, s, old, res, wr;
    if (m_busy != 0) begin
      m_reg[m_sw_b] = m_sw_va;
      m_zero  = (m_sw_va == 0) ? 1 : 0;
      m_carry = 0;
      m_busy  = 0;
    end else if (bif.op_valid) begin
      d = int'(bif.dst); s = int'(bif.src); old = m_reg[d]; res = old; wr = 1;
      case (bif.op)
        3'd1: begin res = int'(bif.RIN); m_carry = 0; end
        3'd2: begin res = 0; m_carry = 0; end
        3'd3: begin res = (old + 1) % 256; m_carry = (old == 255) ? 1 : 0; end
        3'd4: begin res = (old + 255) % 256; m_carry = (old == 0) ? 1 : 0; end
        3'd5: begin res = m_reg[s]; m_carry = 0; end
        3'd6: begin
          wr = 0; m_sw_b = s; m_sw_va = old; m_reg[d] = m_reg[s]; m_busy = 1;
        end
        3'd7: begin res = old / 2; m_carry = old % 2; end
        default: wr = 0;
      endcase
      if (wr != 0) begin
        m_reg[d] = res;
        m_zero = (res == 0) ? 1 : 0;
      end
    end
  endfunction

  function automatic logic [31:0] model_rout();
    return {m_reg[3][7:0], m_reg[2][7:0], m_reg[1][7:0], m_reg[0][7:0]};
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".rout"},  rout, model_rout());
    chk({tag, ".zero"},  {31'd0, zero},  m_zero[31:0]);
    chk({tag, ".carry"}, {31'd0, carry}, m_carry[31:0]);
    chk({tag, ".ready"}, {31'd0, bif.op_ready}, (m_busy == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [1:0] d,
                       input logic [1:0] s, input logic [7:0] r);
    bif.op_valid = v; bif.op = o; bif.dst = d; bif.src = s; bif.RIN = r;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [1:0] dst;
    logic [1:0] src;
    logic [7:0] rin;
    logic [7:0] exp_reg;
    logic       exp_z;
    logic       exp_c;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{3'd1, 2'd2, 2'd0, 8'hA5, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 2'd1, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vecs[2]  = '{3'd3, 2'd1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[3]  = '{3'd4, 2'd1, 2'd0, 8'h00, 8'hFF, 1'b0, 1'b1};
    vecs[4]  = '{3'd0, 2'd1, 2'd0, 8'h00, 8'hFF, 1'b0, 1'b1};
    vecs[5]  = '{3'd1, 2'd0, 2'd0, 8'h03, 8'h03, 1'b0, 1'b0};
    vecs[6]  = '{3'd7, 2'd0, 2'd0, 8'h00, 8'h01, 1'b0, 1'b1};
    vecs[7]  = '{3'd5, 2'd3, 2'd0, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[8]  = '{3'd5, 2'd2, 2'd2, 8'h00, 8'hA5, 1'b0, 1'b0};
    vecs[9]  = '{3'd2, 2'd2, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{3'd4, 2'd2, 2'd0, 8'h00, 8'hFF, 1'b0, 1'b1};
    vecs[11] = '{3'd7, 2'd3, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{3'd3, 2'd0, 2'd0, 8'h00, 8'h02, 1'b0, 1'b0};

    RESET_N = 1'b0; outflag = 1'b0; out_sel = 2'd0;
    drive(1'b0, 3'd0, 2'd0, 2'd0, 8'h00);
    model_reset();
    #12;
    chk("reset.rout",  rout, 32'd0);
    chk("reset.zero",  {31'd0, zero}, 32'd0);
    chk("reset.carry", {31'd0, carry}, 32'd0);
    chk("reset.ready", {31'd0, bif.op_ready}, 32'd1);
    @(negedge clk);
    RESET_N = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].dst, vecs[i].src, vecs[i].rin);
      step();
      chk($sformatf("vec%0d.reg", i), {24'd0, rout[vecs[i].dst*8 +: 8]}, {24'd0, vecs[i].exp_reg});
      chk($sformatf("vec%0d.zero", i), {31'd0, zero}, {31'd0, vecs[i].exp_z});
      chk($sformatf("vec%0d.carry", i), {31'd0, carry}, {31'd0, vecs[i].exp_c});
      chk_model($sformatf("vec%0d", i));
    end

    // Bus driver: selected register when enabled, released (pulled high) otherwise.
    drive(1'b1, 3'd1, 2'd2, 2'd0, 8'hA5);
    step();
    drive(1'b0, 3'd0, 2'd0, 2'd0, 8'h00);
    outflag = 1'b1;
    for (int s = 0; s < 4; s++) begin
      out_sel = s[1:0];
      #1;
      chk($sformatf("checkout.sel%0d", s), {24'd0, checkout_w}, m_reg[s][31:0]);
    end
    out_sel = 2'd2; #1;
    chk("checkout.a5", {24'd0, checkout_w}, 32'h0000_00A5);
    outflag = 1'b0; #1;
    chk("checkout.z", {24'd0, checkout_w}, 32'h0000_00FF);

    // Swap handshake with a LOAD queued behind it.
    drive(1'b1, 3'd1, 2'd0, 2'd0, 8'h11); step();
    drive(1'b1, 3'd1, 2'd1, 2'd0, 8'h22); step();
    drive(1'b1, 3'd6, 2'd0, 2'd1, 8'h00); step();
    chk("swap1.ready", {31'd0, bif.op_ready}, 32'd0);
    chk("swap1.r0", {24'd0, rout[7:0]},  32'h22);
    chk("swap1.r1", {24'd0, rout[15:8]}, 32'h22);
    chk_model("swap1");
    drive(1'b1, 3'd1, 2'd3, 2'd3, 8'h77); step();
    chk("swap2.ready", {31'd0, bif.op_ready}, 32'd1);
    chk("swap2.r1", {24'd0, rout[15:8]}, 32'h11);
    chk("swap2.r0", {24'd0, rout[7:0]},  32'h22);
    chk("swap2.r3_held", {24'd0, rout[31:24]}, 32'h00);
    chk("swap2.zc", {30'd0, zero, carry}, 32'd0);
    chk_model("swap2");
    step();
    chk("swap3.r3", {24'd0, rout[31:24]}, 32'h77);
    chk_model("swap3");

    // Reset in the middle of a swap.
    drive(1'b1, 3'd6, 2'd2, 2'd3, 8'h00); step();
    chk("rswap.ready", {31'd0, bif.op_ready}, 32'd0);
    drive(1'b0, 3'd0, 2'd0, 2'd0, 8'h00);
    RESET_N = 1'b0; model_reset(); #2;
    chk("rswap.rout", rout, 32'd0);
    chk("rswap.ready", {31'd0, bif.op_ready}, 32'd1);
    @(negedge clk);
    RESET_N = 1'b1;
    drive(1'b1, 3'd1, 2'd1, 2'd0, 8'h5A); step();
    chk("rswap.load", {24'd0, rout[15:8]}, 32'h5A);
    chk_model("rswap");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) drive(1'b1, 3'd1, bif.dst, bif.src, 8'($urandom_range(0, 1) * 255));
      outflag = 1'($urandom_range(0, 1));
      out_sel = 2'($urandom_range(0, 3));
      step();
      chk_model($sformatf("rnd%0d", n));
      chk($sformatf("rnd%0d.bus", n), {24'd0, checkout_w},
          outflag ? m_reg[out_sel][31:0] : 32'h0000_00FF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised bank of NREG general-purpose registers, each WIDTH bits, for the model computer datapath. It generalises the single bus register: loading from the data bus, tri-state drive back onto the bus, and asynchronous clear are kept, and it adds in-place arithmetic and move operations plus a two-cycle atomic swap. Operations arrive over a valid/ready command handshake. Zero and carry flags go to the control unit.

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2)
- NREG, 4, number of registers; power of two, ≥2
- AW (localparam), $clog2(NREG), register address width

Ports:
- clk  input  1  single clock; all state changes on rising edge
- RESET_N  input  1  reset, asynchronous assert, active-low
- op_valid  input  1  command present
- op_ready  output  1  bank can accept a command this cycle
- op  input  3  opcode (see Operation)
- dst  input  AW  destination register index
- src  input  AW  source register index (MOV, SWAP)
- RIN  input  WIDTH  data bus input for LOAD
- outflag  input  1  drive checkout onto bus
- out_sel  input  AW  register driven on checkout
- checkout  output  WIDTH  R[out_sel] when outflag=1, else all-Z
- ROUT  output  NREG*WIDTH  all registers flattened, R[i] at bits [i*WIDTH +: WIDTH]
- zero  output  1  last written result was zero
- carry  output  1  carry/borrow/shift-out of last operation

## Operation
- Accept: op_valid && op_ready at a rising clk edge. The command executes at that edge. op/dst/src/RIN are sampled only then.
- Opcodes:
  - 0 NOP: no change; flags hold.
  - 1 LOAD: R[dst]←RIN; carry←0.
  - 2 CLR: R[dst]←0; carry←0.
  - 3 INC: R[dst]←R[dst]+1 mod 2^WIDTH; carry←(old value = all ones).
  - 4 DEC: R[dst]←R[dst]−1 mod 2^WIDTH; carry←(old value = 0), i.e. borrow.
  - 5 MOV: R[dst]←R[src]; carry←0. With src=dst the value is unchanged.
  - 6 SWAP: two cycles, see the FSM below; carry←0.
  - 7 SHR: R[dst]←R[dst]>>1, logical; carry←old bit 0.
- zero←(new value written to dst == 0) on every accepted op except NOP.
- FSM states:
  - IDLE: op_ready=1.
  - SWAP2: op_ready=0.
- IDLE→SWAP2 on an accepted SWAP. At that edge: TMP←R[dst], R[dst]←R[src].
- SWAP2→IDLE unconditionally on the next edge. At that edge: R[src]←TMP; zero←(TMP==0).
- zero and carry are not updated at the first SWAP edge.
- SWAP with src=dst still takes 2 cycles and leaves the register unchanged.
- op_valid is ignored in SWAP2. The requester must hold its next command until op_ready=1.
- checkout is combinational from current register state. It shows intermediate swap values while in SWAP2.
- outflag is independent of the command path. The bus may be driven while a command executes.

## Timing
- Reset (RESET_N=0, asynchronous): all R[i]=0, TMP=0, state IDLE, zero=0, carry=0. op_ready=1 while reset is held and after release.
- Reset during SWAP2 aborts the swap. All registers are 0 and the FSM is in IDLE.
- Single-cycle ops: result is visible on ROUT, checkout, zero and carry immediately after the accepting edge (latency 1).
- SWAP: dst is updated after edge 1 and src after edge 2. op_ready is low for exactly one cycle. Throughput is one SWAP per 2 cycles.
- Back-to-back single-cycle ops are accepted every cycle. Each op reads the register values produced by the previous edge.
- Wrap-around: INC of all-ones gives 0 with carry=1 and zero=1. DEC of 0 gives all-ones with carry=1 and zero=0.
- checkout goes to Z combinationally when outflag=0. out_sel changes take effect combinationally.

## Test plan
- Reset/LOAD: with WIDTH=8, NREG=4, assert RESET_N=0 → ROUT=0, flags 0, op_ready=1. Release, then LOAD dst=2 RIN=8'hA5 → R2=A5, zero=0, carry=0; outflag=1, out_sel=2 → checkout=A5; outflag=0 → checkout=Z.
- Wrap-around: LOAD R1=FF, INC R1 → R1=00, carry=1, zero=1. Then DEC R1 → R1=FF, carry=1, zero=0.
- SHR/MOV: LOAD R0=03, SHR R0 → R0=01, carry=1. MOV dst=3 src=0 → R3=01, zero=0, carry=0.
- SWAP handshake: R0=11, R1=22, SWAP dst=0 src=1 with op_valid held high and a LOAD queued → op_ready=0 for one cycle. After edge 1: R0=22, R1=22. After edge 2: R1=11. The LOAD is accepted only on the third edge.
- Reset mid-swap: start SWAP, pull RESET_N low during SWAP2 → all registers 0, state IDLE, op_ready=1. The next command is accepted normally.
- NOP hold: after DEC 0→FF (carry=1), issue NOP → zero=0, carry=1 unchanged and all registers unchanged.
